step_dir_monitor: RTL and testbench

- Receive-side counterpart of the step/dir motor pulse generator.
- Samples an external STEP/DIR pair, either looped back from the generator pins or taken from another controller.
- Keeps a signed absolute position, measures the step period, and flags protocol violations: DIR changed too close to STEP, or STEP high pulse too short.
- Feeds position readback and closed-loop checking logic in the motor control fabric.

---
 rtl/motor_pkg.sv | 21 ++
 rtl/step_dir_monitor_if.sv | 35 +++
 rtl/sync_edge_det.sv | 38 +++
 rtl/step_dir_monitor.sv | 138 +++++++++++++
 tb/tb_step_dir_monitor.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pkg.sv
// Shared types and default widths for the
// step/dir motor blocks.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    RUN
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int POS_W_DEF       = 19;
  localparam int PERIOD_W_DEF    = 16;
  localparam int DIR_SETUP_DEF   = 255;
  localparam int MIN_HIGH_DEF    = 2;

  function automatic int cntW(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/step_dir_monitor_if.sv
// Readback bundle of the step/dir monitor:
// position, period and status flags.
interface step_dir_monitor_if
  import motor_pkg::*;
#(
  parameter int POS_W    = POS_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
);

  logic signed [POS_W-1:0] position;
  logic [PERIOD_W-1:0]     step_period;
  logic                    period_valid;
  logic                    moving;
  logic                    dir_err;
  logic                    width_err;

  modport master (
    output position,
    output step_period,
    output period_valid,
    output moving,
    output dir_err,
    output width_err
  );

  modport slave (
    input position,
    input step_period,
    input period_valid,
    input moving,
    input dir_err,
    input width_err
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall
// strobes on the synchronized level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic pin,
  output logic q,
  output logic rise,
  output logic fall,
  output logic valid
);

  logic [STAGES-1:0] sync;
  logic [STAGES-1:0] fill;
  logic              prev;

  // fill tracks when q carries a real sample
  // rather than the reset zeros
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      fill <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      fill <= {fill[STAGES-2:0], 1'b1};
      prev <= sync[STAGES-1];
    end
  end

  assign q     = sync[STAGES-1];
  assign rise  = q & ~prev;
  assign fall  = ~q & prev;
  assign valid = fill[STAGES-1];

endmodule

// File: rtl/step_dir_monitor.sv
// Receive-side STEP/DIR decoder: position,
// step period, motion and protocol checks.
module step_dir_monitor
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int PERIOD_W    = PERIOD_W_DEF,
  parameter int DIR_SETUP   = DIR_SETUP_DEF,
  parameter int MIN_HIGH    = MIN_HIGH_DEF
) (
  input  logic CLK,
  input  logic reset,
  input  logic step_in,
  input  logic dir_in,
  input  logic invert_dir,
  input  logic clear_pos,
  input  logic err_clear,
  step_dir_monitor_if.master mon
);

  localparam int DW = cntW(DIR_SETUP);
  localparam int HW = cntW(MIN_HIGH);
  localparam logic [PERIOD_W-1:0] PER_MAX = '1;

  logic stepS, stepRise, stepFall, stepValid;
  logic dirS, dirRise, dirFall, dirValid;
  logic armed;
  logic stepEdge, stepDrop, dirEff;
  logic dirViol, widthViol;
  logic [DW-1:0] dirCnt;
  logic [HW-1:0] hiCnt;
  logic [PERIOD_W-1:0] perCnt;
  logic [POS_W-1:0] posBase, posNext;
  state_t state, stateNext;
  logic movingNext, periodLoad;

  sync_edge_det #(.STAGES(SYNC_STAGES)) uStep (
    .CLK   (CLK),
    .reset (reset),
    .pin   (step_in),
    .q     (stepS),
    .rise  (stepRise),
    .fall  (stepFall),
    .valid (stepValid)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) uDir (
    .CLK   (CLK),
    .reset (reset),
    .pin   (dir_in),
    .q     (dirS),
    .rise  (dirRise),
    .fall  (dirFall),
    .valid (dirValid)
  );

  assign stepEdge  = stepRise & armed;
  assign stepDrop  = stepFall & armed;
  assign dirEff    = dirS ^ invert_dir;
  assign dirViol   = stepEdge && (dirCnt < DW'(DIR_SETUP));
  assign widthViol = stepDrop && (hiCnt < HW'(MIN_HIGH));

  // a coincident clear restarts from zero so the step survives
  assign posBase = clear_pos ? '0 : mon.position;
  assign posNext = dirEff ? posBase + POS_W'(1)
                          : posBase - POS_W'(1);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      armed            <= 1'b0;
      dirCnt           <= '0;
      hiCnt            <= '0;
      perCnt           <= '0;
      state            <= IDLE;
      mon.position     <= '0;
      mon.step_period  <= '0;
      mon.period_valid <= 1'b0;
      mon.moving       <= 1'b0;
      mon.dir_err      <= 1'b0;
      mon.width_err    <= 1'b0;
    end else begin
      armed <= armed | (stepValid & dirValid & ~stepS);
      if (stepEdge)
        mon.position <= posNext;
      else if (clear_pos)
        mon.position <= '0;
      if (dirRise | dirFall)
        dirCnt <= '0;
      else if (dirCnt != DW'(DIR_SETUP))
        dirCnt <= dirCnt + DW'(1);
      // hiCnt includes the rise cycle, so it equals the high width
      if (stepRise)
        hiCnt <= HW'(1);
      else if (stepS && hiCnt != HW'(MIN_HIGH))
        hiCnt <= hiCnt + HW'(1);
      if (stepEdge)
        perCnt <= PERIOD_W'(1);
      else if (perCnt != PER_MAX)
        perCnt <= perCnt + PERIOD_W'(1);
      mon.dir_err   <= dirViol | (mon.dir_err & ~err_clear);
      mon.width_err <= widthViol | (mon.width_err & ~err_clear);
      state            <= stateNext;
      mon.moving       <= movingNext;
      mon.period_valid <= periodLoad;
      if (periodLoad)
        mon.step_period <= perCnt;
    end
  end

  always_comb begin
    stateNext  = state;
    movingNext = mon.moving;
    periodLoad = 1'b0;
    unique case (state)
      IDLE: begin
        if (stepEdge) begin
          stateNext  = TRACK;
          movingNext = 1'b1;
        end
      end
      TRACK, RUN: begin
        if (stepEdge) begin
          stateNext  = RUN;
          periodLoad = 1'b1;
        end else if (perCnt == PER_MAX) begin
          stateNext  = IDLE;
          movingNext = 1'b0;
        end
      end
      default: begin
        stateNext  = IDLE;
        movingNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_step_dir_monitor.sv
// Scoreboard bench for step_dir_monitor: expected
// positions/periods queued at stimulus, popped on change.
module tb_step_dir_monitor;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic step_in = 1'b0;
  logic dir_in = 1'b1;
  logic invert_dir = 1'b0;
  logic clear_pos = 1'b0;
  logic err_clear = 1'b0;

  always #5 CLK = ~CLK;

  step_dir_monitor_if #(.POS_W(19), .PERIOD_W(16)) mIf ();
  step_dir_monitor_if #(.POS_W(4), .PERIOD_W(16)) wIf ();

  step_dir_monitor #(
    .SYNC_STAGES(2), .POS_W(19), .PERIOD_W(16),
    .DIR_SETUP(8), .MIN_HIGH(2)
  ) dut (
    .CLK(CLK), .reset(reset), .step_in(step_in),
    .dir_in(dir_in), .invert_dir(invert_dir),
    .clear_pos(clear_pos), .err_clear(err_clear),
    .mon(mIf)
  );

  step_dir_monitor #(
    .SYNC_STAGES(2), .POS_W(4), .PERIOD_W(16),
    .DIR_SETUP(8), .MIN_HIGH(2)
  ) dutW (
    .CLK(CLK), .reset(reset), .step_in(step_in),
    .dir_in(dir_in), .invert_dir(invert_dir),
    .clear_pos(clear_pos), .err_clear(err_clear),
    .mon(wIf)
  );

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  int mdlPos = 0;
  int lastRise = 0;
  bit lastValid = 1'b0;
  logic signed [18:0] lastSeen = '0;
  logic signed [18:0] posQ[$];
  logic [15:0] perQ[$];

  always @(posedge CLK) cyc++;

  task automatic check(input string name,
                       input longint got,
                       input longint exp);
    totalCnt++;
    if (got == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d",
                  name, got, exp);
  endtask

  always @(negedge CLK) begin
    if (mIf.period_valid === 1'b1) begin
      if (perQ.size() == 0) begin
        totalCnt++;
        $display("FAIL period_unexpected: got %0d, expected none",
                 mIf.step_period);
      end else
        check("step_period", mIf.step_period, perQ.pop_front());
    end
    if (mIf.position !== lastSeen) begin
      if (posQ.size() == 0) begin
        totalCnt++;
        $display("FAIL position_unexpected: got %0d, expected %0d",
                 mIf.position, lastSeen);
      end else
        check("position", mIf.position, posQ.pop_front());
      lastSeen = mIf.position;
    end
  end

  task automatic setPos(input int v);
    if (v != mdlPos) posQ.push_back(19'(v));
    mdlPos = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitN(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int hi, input int lo,
                       input bit clr = 1'b0);
    int d;
    step_in = 1'b1;
    if (lastValid && (cyc - lastRise) <= 65535)
      perQ.push_back(16'(cyc - lastRise));
    lastRise = cyc;
    lastValid = 1'b1;
    d = (dir_in ^ invert_dir) ? 1 : -1;
    setPos((clr ? 0 : mdlPos) + d);
    for (int i = 0; i < hi + lo; i++) begin
      step();
      if (i + 1 == hi) step_in = 1'b0;
      clear_pos = clr && (i + 1 == 2);
    end
    clear_pos = 1'b0;
  endtask

  task automatic clearOnly();
    setPos(0);
    clear_pos = 1'b1;
    step();
    clear_pos = 1'b0;
  endtask

  task automatic errClear();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  initial begin
    waitN(3);
    reset = 1'b1;
    waitN(3);
    check("rst_position", mIf.position, 0);
    check("rst_period", mIf.step_period, 0);
    check("rst_valid", mIf.period_valid, 0);
    check("rst_moving", mIf.moving, 0);
    check("rst_dir_err", mIf.dir_err, 0);
    check("rst_width_err", mIf.width_err, 0);
    waitN(20);

    repeat (5) pulse(50, 50);
    check("run_position", mIf.position, 5);
    check("run_moving", mIf.moving, 1);
    check("run_period", mIf.step_period, 100);
    check("run_dir_err", mIf.dir_err, 0);
    waitN(65300);
    check("pre_timeout_moving", mIf.moving, 1);
    waitN(300);
    check("timeout_moving", mIf.moving, 0);
    check("timeout_period_hold", mIf.step_period, 100);
    check("timeout_idle",
          int'(dut.state == motor_pkg::IDLE), 1);

    clearOnly();
    waitN(2);
    check("clear_alone", mIf.position, 0);
    dir_in = 1'b0;
    waitN(3);
    pulse(4, 20);
    check("dir_err_set", mIf.dir_err, 1);
    check("dir_err_width", mIf.width_err, 0);
    check("dir_err_pos", mIf.position, -1);
    errClear();
    check("dir_err_clear", mIf.dir_err, 0);

    dir_in = 1'b1;
    waitN(20);
    clearOnly();
    waitN(2);
    repeat (8) pulse(4, 16);
    check("wide_pos8", mIf.position, 8);
    check("wrap_pos8", wIf.position, -8);
    pulse(4, 16);
    check("wrap_pos9", wIf.position, -7);
    pulse(4, 16);
    check("pos10", mIf.position, 10);

    dir_in = 1'b0;
    waitN(20);
    pulse(4, 16, 1'b1);
    check("clear_step", mIf.position, -1);
    check("clear_step_w", wIf.position, -1);
    check("clear_step_err", mIf.dir_err, 0);
    invert_dir = 1'b1;
    pulse(4, 16);
    check("invert_up", mIf.position, 0);
    invert_dir = 1'b0;
    dir_in = 1'b1;
    waitN(20);

    pulse(2, 20);
    check("width2_ok", mIf.width_err, 0);
    pulse(1, 20);
    check("width1_err", mIf.width_err, 1);
    check("width1_pos", mIf.position, 2);
    errClear();
    check("width_clear", mIf.width_err, 0);

    setPos(0);
    step_in = 1'b1;
    reset = 1'b0;
    lastValid = 1'b0;
    waitN(3);
    reset = 1'b1;
    waitN(20);
    check("held_high_pos", mIf.position, 0);
    check("held_high_moving", mIf.moving, 0);
    step_in = 1'b0;
    waitN(10);
    step_in = 1'b1;
    setPos(1);
    lastRise = cyc;
    lastValid = 1'b1;
    waitN(2);
    check("latency_early", mIf.position, 0);
    step();
    check("latency_pos", mIf.position, 1);
    step_in = 1'b0;
    waitN(10);

    check("posQ_empty", posQ.size(), 0);
    check("perQ_empty", perQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
